// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
// Latches floor calls into a pending bitmap and dispatches target floors to the
// elevator with a LOOK policy. The car keeps its sweep direction while calls lie
// ahead of it and reverses otherwise.
// Optional build macro: ELEV_SCHED_DWELL_EN. When it is defined, the door state
// holds for DWELL_CYCLES clocks. When it is undefined, the door state lasts one
// clock and no dwell counter is built.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no trip in flight; waiting for a pending call
// S_SELECT | one cycle to pick the next target from pending and dir_up
// S_TRAVEL | target dispatched; waiting for the car to go idle at the target
// S_DOOR   | car stopped at a served floor; door open
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = 4,
  parameter int DWELL_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  call_reject,
  output logic                  door_open
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_TRAVEL, S_DOOR} state_t;

  localparam logic [FLOOR_W:0]      NF  = (FLOOR_W+1)'(NUM_FLOORS);
  localparam logic [NUM_FLOORS-1:0] ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  state_t                state;
  logic                  call_in_range;
  logic                  cur_in_range;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] tgt_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic                  cur_pending;
  logic                  arrived;
  logic                  door_done;
  logic                  have_up;
  logic                  have_dn;
  logic [FLOOR_W-1:0]    up_floor;
  logic [FLOOR_W-1:0]    dn_floor;

  assign call_in_range = ({1'b0, call_floor} < NF);
  assign cur_in_range  = ({1'b0, current_floor} < NF);
  assign set_mask      = (call_valid && call_in_range) ? (ONE << call_floor) : '0;
  assign cur_mask      = cur_in_range ? (ONE << current_floor) : '0;
  assign tgt_mask      = ONE << target_floor;
  assign cur_pending   = |(pending & cur_mask);
  assign arrived       = car_idle && (current_floor == target_floor);

`ifdef ELEV_SCHED_DWELL_EN
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

  logic [DWELL_W-1:0] dwell_cnt;

  // Dwell timer: it stays at zero outside S_DOOR and counts the cycles spent in S_DOOR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dwell_cnt <= '0;
    else if (state != S_DOOR)
      dwell_cnt <= '0;
    else
      dwell_cnt <= dwell_cnt + 1'b1;
  end

  assign door_done = (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
`else
  logic unused_dwell;
  assign unused_dwell = (DWELL_CYCLES != 0);
  assign door_done    = 1'b1;
`endif

  // Service clears: the floor at which the car stops, the reached target, and any call made at the open door.
  always_comb begin
    clr_mask = '0;
    case (state)
      S_IDLE:   if (cur_pending && car_idle) clr_mask = cur_mask;
      S_TRAVEL: if (arrived) clr_mask = tgt_mask;
      S_DOOR:   clr_mask = cur_mask;
      default:  clr_mask = '0;
    endcase
  end

  // Nearest pending call above the car (lowest such floor) and below it (highest such floor).
  always_comb begin
    have_up  = 1'b0;
    have_dn  = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
        have_up  = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
        have_dn  = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
  end

  // Pending bitmap and reject flag. A clear beats a set on the same bit, so a call to a served floor is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      call_reject <= 1'b0;
    end else begin
      pending     <= (pending | set_mask) & ~clr_mask;
      call_reject <= call_valid && !call_in_range;
    end
  end

  // LOOK sequencer with registered target, direction and door outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      target_floor <= '0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
      door_open    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cur_pending && car_idle) begin
            state     <= S_DOOR;
            door_open <= 1'b1;
          end else if (|pending) begin
            state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (dir_up) begin
            if (have_up) begin
              target_floor <= up_floor;
              target_valid <= 1'b1;
              state        <= S_TRAVEL;
            end else if (have_dn) begin
              target_floor <= dn_floor;
              target_valid <= 1'b1;
              dir_up       <= 1'b0;
              state        <= S_TRAVEL;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            if (have_dn) begin
              target_floor <= dn_floor;
              target_valid <= 1'b1;
              state        <= S_TRAVEL;
            end else if (have_up) begin
              target_floor <= up_floor;
              target_valid <= 1'b1;
              dir_up       <= 1'b1;
              state        <= S_TRAVEL;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_TRAVEL: begin
          if (arrived) begin
            target_valid <= 1'b0;
            door_open    <= 1'b1;
            state        <= S_DOOR;
          end
        end
        S_DOOR: begin
          if (door_done) begin
            door_open <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler. The stimulus pushes each expected
// dispatch, door and reject event into a queue. A monitor pops an entry and
// compares it whenever the scheduler presents such an event.
module tb_elevator_request_scheduler;
  localparam int NF = 10;
  localparam int FW = 4;
  localparam int DW = 4;
`ifdef ELEV_SCHED_DWELL_EN
  localparam int DOOR_LEN = DW;
`else
  localparam int DOOR_LEN = 1;
`endif

  localparam int EV_TGT  = 0;
  localparam int EV_DOOR = 1;
  localparam int EV_REJ  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          call_valid;
  logic [FW-1:0] call_floor;
  logic [FW-1:0] current_floor;
  logic          car_idle;
  logic [FW-1:0] target_floor;
  logic          target_valid;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          call_reject;
  logic          door_open;

  typedef struct {int kind; int val; int aux;} ev_t;
  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .current_floor(current_floor), .car_idle(car_idle), .target_floor(target_floor),
    .target_valid(target_valid), .dir_up(dir_up), .pending(pending),
    .call_reject(call_reject), .door_open(door_open)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int val, input int aux);
    ev_t e;
    e.kind = kind; e.val = val; e.aux = aux;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int val, input int aux);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_val", val, e.val);
      check("event_aux", aux, e.aux);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic prev_tv;
    logic prev_door;
    int   door_len;
    prev_tv = 1'b0; prev_door = 1'b0; door_len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_tv = 1'b0; prev_door = 1'b0; door_len = 0;
      end else begin
        if (target_valid && !prev_tv) pop_cmp(EV_TGT, int'(target_floor), int'(dir_up));
        if (call_reject) pop_cmp(EV_REJ, int'(pending), 0);
        if (door_open) door_len++;
        else if (prev_door) begin
          pop_cmp(EV_DOOR, door_len, 0);
          door_len = 0;
        end
        prev_tv   = target_valid;
        prev_door = door_open;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic call(input int f);
    call_valid = 1'b1;
    call_floor = FW'(f);
    tick();
    call_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pending"}, int'(pending), 0);
    check({tag, "_target_floor"}, int'(target_floor), 0);
    check({tag, "_target_valid"}, int'(target_valid), 0);
    check({tag, "_dir_up"}, int'(dir_up), 1);
    check({tag, "_call_reject"}, int'(call_reject), 0);
    check({tag, "_door_open"}, int'(door_open), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; call_valid = 1'b0; call_floor = '0;
    current_floor = '0; car_idle = 1'b1;
    tick(); tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    // Car at 0, call floor 3: pending is set at once and the target appears two cycles later.
    push(EV_TGT, 3, 1);
    call(3);
    check("t1_pending", int'(pending), 'h008);
    check("t1_tv_k", int'(target_valid), 0);
    tick();
    check("t1_tv_k1", int'(target_valid), 0);
    tick();
    check("t1_tv_k2", int'(target_valid), 1);
    check("t1_target", int'(target_floor), 3);
    check("t1_dir", int'(dir_up), 1);
    push(EV_DOOR, DOOR_LEN, 0);
    current_floor = 4'd3;
    tick();
    repeat (DOOR_LEN + 2) tick();
    check("t1_pending_end", int'(pending), 0);
    check("t1_tv_end", int'(target_valid), 0);
    check("t1_target_hold", int'(target_floor), 3);

    // Idle car at 4, call to floor 4: the door opens and no target is dispatched.
    current_floor = 4'd4;
    tick();
    push(EV_DOOR, DOOR_LEN, 0);
    call(4);
    tick();
    check("t4_door", int'(door_open), 1);
    check("t4_tv", int'(target_valid), 0);
    repeat (DOOR_LEN + 1) tick();
    check("t4_pending", int'(pending), 0);
    check("t4_tv_end", int'(target_valid), 0);
    check("t4_door_end", int'(door_open), 0);

    // Car at 5 heading to 7, calls 2 and 9: serve 7, then 9, then reverse to 2.
    current_floor = 4'd5;
    tick();
    push(EV_TGT, 7, 1);
    call(7);
    tick(); tick();
    call(2);
    call(9);
    check("t2_pending", int'(pending), 'h284);
    check("t2_target7", int'(target_floor), 7);
    push(EV_DOOR, DOOR_LEN, 0);
    push(EV_TGT, 9, 1);
    current_floor = 4'd7;
    tick();
    repeat (DOOR_LEN + 3) tick();
    check("t2_target9", int'(target_floor), 9);
    check("t2_tv9", int'(target_valid), 1);
    push(EV_DOOR, DOOR_LEN, 0);
    push(EV_TGT, 2, 0);
    current_floor = 4'd9;
    tick();
    repeat (DOOR_LEN + 3) tick();
    check("t2_target2", int'(target_floor), 2);
    check("t2_dir_down", int'(dir_up), 0);
    push(EV_DOOR, DOOR_LEN, 0);
    current_floor = 4'd2;
    tick();
    repeat (DOOR_LEN + 2) tick();
    check("t2_pending_end", int'(pending), 0);

    // Out-of-range call: one reject pulse, and nothing else changes.
    push(EV_REJ, 0, 0);
    call(12);
    check("t3_reject", int'(call_reject), 1);
    check("t3_pending", int'(pending), 0);
    tick();
    check("t3_reject_off", int'(call_reject), 0);
    tick();
    check("t3_tv", int'(target_valid), 0);

    // Reset during travel with 0x0F0 pending: outputs return to reset values at once.
    current_floor = 4'd0;
    tick();
    push(EV_TGT, 4, 1);
    call(4); call(5); call(6); call(7);
    check("t5_pending", int'(pending), 'h0F0);
    check("t5_tv", int'(target_valid), 1);
    check("t5_target", int'(target_floor), 4);
    #2 reset = 1'b1;
    #1 check_reset_values("t5_async");
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) tick();
    check("t5_tv_after", int'(target_valid), 0);
    check("t5_pending_after", int'(pending), 0);

    // Arrival at floor 6: door dwell length, and a call to floor 6 during the dwell is not latched.
    push(EV_TGT, 6, 1);
    call(6);
    tick(); tick();
    check("t6_target", int'(target_floor), 6);
    push(EV_DOOR, DOOR_LEN, 0);
    current_floor = 4'd6;
    tick();
    check("t6_door", int'(door_open), 1);
    call(6);
    repeat (DOOR_LEN + 3) tick();
    check("t6_pending", int'(pending), 0);
    check("t6_tv", int'(target_valid), 0);
    check("t6_door_end", int'(door_open), 0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
